uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//   Receive side of the UART link: recovers 8N1/8E1 frames from the serial rx line and
//   presents each byte with rx_valid, parity_error and frame_error strobes.
//   Sits between the rx pin and the receive datapath, opposite end of the uart_tx serializer.
//   The bit period is runtime-programmable through clk_per_bit.
// PARAMETERS
//   DATA_BITS    8   payload bits per frame, LSB first
//   SYNC_STAGES  2   flops in the rx metastability synchronizer (>=2)
//   PARITY_ODD   0   0 = even parity, 1 = odd parity (used only when parity_en=1)
// PORTS
//   clk           in   1          system clock
//   rst_n         in   1          synchronous active-low reset
//   rx            in   1          asynchronous serial input, idle high
//   parity_en     in   1          1 = frame carries a parity bit after the data
//   clk_per_bit   in   13         clocks per bit; values <4 are treated as 4
//   rx_data       out  DATA_BITS  last received byte, held until the next frame completes
//   rx_valid      out  1          1-cycle strobe: good stop bit, rx_data updated
//   parity_error  out  1          1-cycle strobe coincident with rx_valid on parity mismatch
//   frame_error   out  1          1-cycle strobe: stop bit sampled 0
//   rx_busy       out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-low (clk, rst_n).
// - Reset (rst_n=0 at posedge clk):
//   - rx_data=0, rx_valid=0, parity_error=0, frame_error=0, rx_busy=0.
//   - Synchronizer flops = 1; state = IDLE.
// - Reset mid-frame aborts the frame; no strobe is emitted.
// - rx passes through SYNC_STAGES flops; rxs = synchronized rx. All decisions use rxs.
// - cpb = max(clk_per_bit,4), latched on start detect; mid-frame changes are ignored.
// - 13-bit counter cnt; every sample point reloads cnt=0.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - IDLE:
//   - rxs 1->0 (previous-cycle rxs=1, current rxs=0) -> START, cnt=0, rx_busy=1.
//   - A line held low (e.g. after a frame error) does not retrigger; it needs a fresh falling edge.
// - START: at cnt == (cpb>>1)-1, sample rxs.
//   - rxs=1 -> false start -> IDLE, no strobe.
//   - rxs=0 -> DATA.
// - DATA: sample at cnt==cpb-1.
//   - Shift into the shift register, LSB first.
//   - After DATA_BITS samples -> PARITY if parity_en, else STOP.
// - PARITY: sample at cnt==cpb-1; latch mismatch = (^data ^ rxs ^ PARITY_ODD).
// - STOP: sample at cnt==cpb-1.
//   - rxs=1: next cycle rx_data<=shift reg, rx_valid=1, parity_error=mismatch&parity_en.
//   - rxs=0: next cycle frame_error=1, rx_valid=0, parity_error=0, rx_data unchanged.
//   - Either case -> IDLE, rx_busy=0 in the same cycle as the strobe.
// - Strobes are exactly 1 cycle; rx_valid and frame_error are never high together.
// - Sample points lie mid-bit: stop-bit sample is at (cpb>>1)-1 + (1+DATA_BITS+parity_en)*cpb
//   cycles after the synchronized falling edge.
// - Strobe latency is one cycle after the stop-bit sample, plus SYNC_STAGES from the pin.
// - Back-to-back frames: a falling edge on the cycle after the strobe is accepted.
// - No receive buffer: a new byte overwrites rx_data; the consumer must take it on rx_valid.
// TESTING
//   1. cpb=16, parity_en=0, send 0xA5 with stop=1 -> one rx_valid, rx_data=0xA5,
//      no error strobes, rx_busy low after.
//   2. cpb=16, parity_en=1, send 0x3C with parity=0 (even) -> rx_valid, parity_error=0;
//      resend with parity=1 -> rx_valid and parity_error together, rx_data=0x3C.
//   3. cpb=16, send 0x55 with stop=0, rx held low 40 cycles -> frame_error 1 cycle,
//      rx_valid=0, rx_data keeps prior value, no retrigger until rx rises then falls.
//   4. rx low pulse of 5 cycles at cpb=16 -> false start, return to IDLE, no strobes.
//   5. cpb=4 and cpb=2 (clamped to 4), frames 0x00 then 0xFF back-to-back with no idle gap
//      -> two rx_valid strobes, rx_data 0x00 then 0xFF.
//   6. rst_n=0 during DATA bit 3 -> all outputs 0 next cycle; clean 0x81 frame after reset
//      is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer_if.sv
// uart_rx_deserializer_if
//   Receive-side byte bus from the UART deserializer to the receive datapath.
//   master : driven by the deserializer (byte plus status strobes)
//   slave  : consumer view of the same signals
//   rx_data       DATA_BITS  last received byte, held until the next good frame
//   rx_valid      1          1-cycle strobe, rx_data just updated
//   parity_error  1          1-cycle strobe alongside rx_valid on parity mismatch
//   frame_error   1          1-cycle strobe, stop bit sampled low
//   rx_busy       1          frame reception in progress
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_error;
  logic                 frame_error;
  logic                 rx_busy;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_error,
    output frame_error,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input parity_error,
    input frame_error,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Recovers 8N1 / 8E1 (or 8O1) frames from the asynchronous rx pin and presents
//   each byte on the receive bus with valid / parity / framing strobes.
//   Bit period is programmable at run time via clk_per_bit (clamped to >= 4).
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   rx           in   asynchronous serial input, idle high
//   parity_en    in   frame carries a parity bit after the data bits
//   clk_per_bit  in   13-bit clocks per bit
//   rx_bus       master modport: rx_data, rx_valid, parity_error, frame_error, rx_busy
module uart_rx_deserializer #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          parity_en,
  input  logic [12:0]                   clk_per_bit,
  uart_rx_deserializer_if.master        rx_bus
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                 rxs;
  logic                 rxs_prev;

  logic [12:0]          cnt;
  logic [12:0]          cpb;
  logic [12:0]          half_m1;
  logic [12:0]          full_m1;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 mismatch;
  logic                 pen;

  logic                 start_det;
  logic                 smp_hit;
  logic                 smp_data;
  logic                 smp_par;
  logic                 stop_ok;
  logic                 stop_bad;

  // Metastability synchronizer; resets to the idle-high line level so that
  // leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff  <= '1;
      rxs_prev <= 1'b1;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], rx};
      rxs_prev <= rxs;
    end
  end

  assign rxs     = sync_ff[SYNC_STAGES-1];
  assign half_m1 = (cpb >> 1) - 13'd1;
  assign full_m1 = cpb - 13'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and sample-point decode
  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    smp_hit   = 1'b0;
    smp_data  = 1'b0;
    smp_par   = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line stuck low does not.
        if (rxs_prev && !rxs) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == half_m1) begin
          smp_hit   = 1'b1;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == full_m1) begin
          smp_hit  = 1'b1;
          smp_data = 1'b1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
            state_nxt = pen ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (cnt == full_m1) begin
          smp_hit   = 1'b1;
          smp_par   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == full_m1) begin
          smp_hit   = 1'b1;
          stop_ok   = rxs;
          stop_bad  = !rxs;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and payload capture. Bit period and parity mode are frozen at
  // start detect so mid-frame changes cannot corrupt the frame in flight.
  always_ff @(posedge clk) begin
    if (start_det || smp_hit) begin
      cnt <= 13'd0;
    end else begin
      cnt <= cnt + 13'd1;
    end

    if (start_det) begin
      cpb      <= (clk_per_bit < 13'd4) ? 13'd4 : clk_per_bit;
      pen      <= parity_en;
      bit_idx  <= '0;
      mismatch <= 1'b0;
    end else begin
      if (smp_data) begin
        shift   <= {rxs, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + IDX_W'(1);
      end
      if (smp_par) begin
        mismatch <= (^shift) ^ rxs ^ 1'(PARITY_ODD);
      end
    end
  end

  // Output strobes, registered one cycle after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_bus.rx_data      <= '0;
      rx_bus.rx_valid     <= 1'b0;
      rx_bus.parity_error <= 1'b0;
      rx_bus.frame_error  <= 1'b0;
    end else begin
      rx_bus.rx_valid     <= stop_ok;
      rx_bus.parity_error <= stop_ok & mismatch & pen;
      rx_bus.frame_error  <= stop_bad;
      if (stop_ok) begin
        rx_bus.rx_data <= shift;
      end
    end
  end

  // Busy drops in the strobe cycle because the FSM is already back in IDLE.
  assign rx_bus.rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
//   Directed frames on the rx line; expected receive-bus events are queued when
//   a frame is issued and an independent monitor pops and compares them
//   whenever the DUT raises rx_valid or frame_error.
module tb_uart_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        parity_en = 1'b0;
  logic [12:0] clk_per_bit = 13'd16;

  uart_rx_deserializer_if #(.DATA_BITS(8)) bus ();

  uart_rx_deserializer #(
    .DATA_BITS  (8),
    .SYNC_STAGES(2),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .parity_en  (parity_en),
    .clk_per_bit(clk_per_bit),
    .rx_bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold the line at v for n clock periods (inputs change on the falling edge).
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame; exp_perr is the hand-computed parity-error outcome.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input logic exp_perr);
    int   bt;
    exp_t e;
    bt = (clk_per_bit < 13'd4) ? 4 : int'(clk_per_bit);
    if (stop) begin
      e.data    = d;
      e.perr    = exp_perr;
      e.ferr    = 1'b0;
      last_data = d;
    end else begin
      e.data = last_data;
      e.perr = 1'b0;
      e.ferr = 1'b1;
    end
    sb.push_back(e);
    hold(1'b0, bt);
    for (int i = 0; i < 8; i++) hold(d[i], bt);
    if (pen) hold(pbit, bt);
    hold(stop, bt);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({"drain_", name}, sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name, input logic [7:0] exp_data);
    check({name, "_rx_valid"}, bus.rx_valid, 0);
    check({name, "_parity_error"}, bus.parity_error, 0);
    check({name, "_frame_error"}, bus.frame_error, 0);
    check({name, "_rx_busy"}, bus.rx_busy, 0);
    check({name, "_rx_data"}, bus.rx_data, exp_data);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.rx_valid || bus.frame_error)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {bus.rx_valid, bus.frame_error}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("mon_rx_valid", bus.rx_valid, !mon_e.ferr);
        check("mon_frame_error", bus.frame_error, mon_e.ferr);
        check("mon_parity_error", bus.parity_error, mon_e.perr);
        check("mon_rx_data", bus.rx_data, mon_e.data);
      end
    end
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // 1: plain 8N1 byte
    clk_per_bit = 13'd16;
    parity_en   = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("t1");
    check("t1_busy_after", bus.rx_busy, 0);
    check("t1_rx_data", bus.rx_data, 8'hA5);
    hold(1'b1, 10);

    // 2: even parity, correct then wrong parity bit (0x3C has four ones)
    parity_en = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("t2");
    parity_en = 1'b0;
    hold(1'b1, 10);

    // 3: bad stop bit, line left low; rx_data must keep 0x3C, no retrigger
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 40);
    check("t3_no_retrigger_busy", bus.rx_busy, 0);
    drain("t3");
    check("t3_rx_data_held", bus.rx_data, 8'h3C);
    hold(1'b1, 20);

    // 4: 5-cycle glitch is a false start
    hold(1'b0, 4);
    check("t4_busy_on_start", bus.rx_busy, 1);
    hold(1'b0, 1);
    hold(1'b1, 30);
    check("t4_busy_after_false_start", bus.rx_busy, 0);
    check("t4_rx_data_unchanged", bus.rx_data, 8'h3C);

    // 5: minimum bit period, and a too-small period clamped to 4, back-to-back
    clk_per_bit = 13'd4;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("t5_cpb4");
    hold(1'b1, 10);
    clk_per_bit = 13'd2;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("t5_cpb2");
    check("t5_rx_data", bus.rx_data, 8'hFF);
    hold(1'b1, 10);

    // 6: reset in the middle of data bit 3, then a clean frame
    clk_per_bit = 13'd16;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 8);
    check("t6_busy_before_reset", bus.rx_busy, 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    check_idle_outputs("t6_reset", 8'h00);
    rst_n     = 1'b1;
    last_data = 8'h00;
    hold(1'b1, 20);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("t6");
    check("t6_busy_after", bus.rx_busy, 0);
    hold(1'b1, 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
